// File: rtl/td4_pkg.sv
// Shared TD4 datapath definitions: select encoding, select type and legal data width range.
package td4_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A = 2'd0;
   localparam sel_t SEL_B = 2'd1;
   localparam sel_t SEL_C = 2'd2;
   localparam sel_t SEL_D = 2'd3;

   localparam int BITWIDTH_MIN = 32'sd1;
   localparam int BITWIDTH_MAX = 32'sd32;

   // True when the requested source differs from the one last captured.
   function automatic logic sel_changed(input sel_t i_new, input sel_t i_old);
      return (i_new != i_old) ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/data_selector_mux4.sv
// Purely combinational 4:1 source mux for the TD4 operand path.
module data_selector_mux4
   import td4_pkg::*;
#(
   parameter int bitWidth = 4
)
(
   input  logic [bitWidth-1:0] i_a,
   input  logic [bitWidth-1:0] i_b,
   input  logic [bitWidth-1:0] i_c,
   input  logic [bitWidth-1:0] i_d,
   input  sel_t                i_sel,
   output logic [bitWidth-1:0] o_y
);

   // An unknown select propagates as all-X so simulation exposes it.
   always_comb begin
      o_y = {bitWidth{1'bx}};
      case (i_sel)
         SEL_A:   o_y = i_a;
         SEL_B:   o_y = i_b;
         SEL_C:   o_y = i_c;
         SEL_D:   o_y = i_d;
         default: o_y = {bitWidth{1'bx}};
      endcase
   end

endmodule

// File: rtl/data_selector.sv
// TD4 operand selector: combinational Y plus a captured copy (YQ/SELQ).
// Optional SEL_CHG source-switch pulse is enabled by macro DATA_SELECTOR_SELCHG_EN.
module data_selector
   import td4_pkg::*;
#(
   parameter int bitWidth = 4
)
(
   input  logic                CLK,
   input  logic                nRESET,
   input  logic [bitWidth-1:0] A,
   input  logic [bitWidth-1:0] B,
   input  logic [bitWidth-1:0] C,
   input  logic [bitWidth-1:0] D,
   input  logic [1:0]          OE,
   input  logic                EN,
   output logic [bitWidth-1:0] Y,
   output logic [bitWidth-1:0] YQ,
   output logic [1:0]          SELQ
`ifdef DATA_SELECTOR_SELCHG_EN
   ,
   output logic                SEL_CHG
`endif
);

   generate
      if ((bitWidth < BITWIDTH_MIN) || (bitWidth > BITWIDTH_MAX)) begin : g_bad_width
         $error("data_selector: bitWidth %0d outside 1..32", bitWidth);
      end
   endgenerate

   logic [bitWidth-1:0] w_y;
   logic [bitWidth-1:0] r_yq;
   sel_t                r_selq;

   data_selector_mux4 #(
      .bitWidth (bitWidth)
   ) u_mux4 (
      .i_a   (A),
      .i_b   (B),
      .i_c   (C),
      .i_d   (D),
      .i_sel (OE),
      .o_y   (w_y)
   );

   assign Y    = w_y;
   assign YQ   = r_yq;
   assign SELQ = r_selq;

   // Capture stage: async clear, load on EN, otherwise hold.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_yq   <= {bitWidth{1'b0}};
         r_selq <= SEL_A;
      end else if (EN) begin
         r_yq   <= w_y;
         r_selq <= OE;
      end else begin
         r_yq   <= r_yq;
         r_selq <= r_selq;
      end
   end

`ifdef DATA_SELECTOR_SELCHG_EN
   logic r_sel_chg;

   assign SEL_CHG = r_sel_chg;

   // One-cycle pulse when a capture switches to a different source.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_sel_chg <= 1'b0;
      end else if (EN) begin
         r_sel_chg <= sel_changed(OE, r_selq);
      end else begin
         r_sel_chg <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_data_selector.sv
// Scoreboard bench for data_selector: stimulus queues expectations, a monitor checks them on strobe.
module tb_data_selector;

   localparam int W      = 4;
   localparam int S_Y    = 0;
   localparam int S_YQ   = 1;
   localparam int S_SELQ = 2;
   localparam int S_CHG  = 3;

   typedef struct {
      string       nm;
      int          sig;
      logic [31:0] exp;
   } sb_item_t;

   logic         clk;
   logic         clk_en;
   logic         n_reset;
   logic [W-1:0] a, b, c, d;
   logic [1:0]   oe;
   logic         en;
   logic [W-1:0] y, yq;
   logic [1:0]   selq;
`ifdef DATA_SELECTOR_SELCHG_EN
   logic         sel_chg;
`endif

   sb_item_t sb_q[$];
   event     ev_check;
   int       n_checks;
   int       n_pass;

   data_selector #(.bitWidth(W)) dut (
      .CLK    (clk),
      .nRESET (n_reset),
      .A      (a),
      .B      (b),
      .C      (c),
      .D      (d),
      .OE     (oe),
      .EN     (en),
      .Y      (y),
      .YQ     (yq),
      .SELQ   (selq)
`ifdef DATA_SELECTOR_SELCHG_EN
      ,
      .SEL_CHG(sel_chg)
`endif
   );

   // Clock only toggles once enabled, so early tests see CLK tied low.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   function automatic logic [31:0] actual_of(input int sig);
      case (sig)
         S_Y:    return {28'd0, y};
         S_YQ:   return {28'd0, yq};
         S_SELQ: return {30'd0, selq};
`ifdef DATA_SELECTOR_SELCHG_EN
         S_CHG:  return {31'd0, sel_chg};
`endif
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic expect_val(input string nm, input int sig, input logic [31:0] v);
      sb_item_t it;
      it.nm  = nm;
      it.sig = sig;
      it.exp = v;
      sb_q.push_back(it);
   endtask

   task automatic strobe();
      -> ev_check;
      #1;
   endtask

   task automatic edge_and_settle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: drain all queued expectations each time the stimulus strobes.
   initial begin
      sb_item_t    it;
      logic [31:0] act;
      forever begin
         @(ev_check);
         while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = actual_of(it.sig);
            n_checks++;
            if (act === it.exp) n_pass++;
            else $display("FAIL %s: got %0h, expected %0h", it.nm, act, it.exp);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      clk      = 1'b0;
      clk_en   = 1'b0;
      n_reset  = 1'b0;
      en       = 1'b0;
      oe       = 2'd0;
      a = 4'd3; b = 4'd5; c = 4'd7; d = 4'd9;
      #2;
      expect_val("reset_yq", S_YQ, 32'd0);
      expect_val("reset_selq", S_SELQ, 32'd0);
`ifdef DATA_SELECTOR_SELCHG_EN
      expect_val("reset_selchg", S_CHG, 32'd0);
`endif
      strobe();
      n_reset = 1'b1;
      #1;

      // Combinational select with the clock idle
      for (int i = 0; i < 4; i++) begin
         oe = i[1:0];
         #1;
         case (i)
            0:       expect_val("comb_oe0", S_Y, 32'd3);
            1:       expect_val("comb_oe1", S_Y, 32'd5);
            2:       expect_val("comb_oe2", S_Y, 32'd7);
            default: expect_val("comb_oe3", S_Y, 32'd9);
         endcase
         strobe();
      end
      expect_val("no_clock_yq", S_YQ, 32'd0);
      strobe();

      oe = 2'd2;
      c  = 4'hA;
      #1;
      expect_val("track_c", S_Y, 32'd10);
      strobe();

      // Capture then hold
      clk_en = 1'b1;
      oe = 2'd1;
      b  = 4'd5;
      en = 1'b1;
      edge_and_settle();
      expect_val("cap_yq", S_YQ, 32'd5);
      expect_val("cap_selq", S_SELQ, 32'd1);
      strobe();
      en = 1'b0;
      oe = 2'd3;
      edge_and_settle();
      edge_and_settle();
      expect_val("hold_yq", S_YQ, 32'd5);
      expect_val("hold_selq", S_SELQ, 32'd1);
      expect_val("hold_y", S_Y, 32'd9);
      strobe();

      // Asynchronous reset between edges
      @(negedge clk);
      #1;
      n_reset = 1'b0;
      #1;
      expect_val("arst_yq", S_YQ, 32'd0);
      expect_val("arst_selq", S_SELQ, 32'd0);
      expect_val("arst_y", S_Y, 32'd9);
      strobe();
      en = 1'b1;
      edge_and_settle();
      expect_val("rst_over_cap_yq", S_YQ, 32'd0);
      strobe();

      // Release: first capture on the next rising edge
      @(negedge clk);
      #1;
      n_reset = 1'b1;
      #1;
      expect_val("rel_pre_yq", S_YQ, 32'd0);
      strobe();
      edge_and_settle();
      expect_val("rel_yq", S_YQ, 32'd9);
      expect_val("rel_selq", S_SELQ, 32'd3);
      strobe();

      // One-cycle latency from data change to YQ
      d = 4'd6;
      #1;
      expect_val("lat_y", S_Y, 32'd6);
      expect_val("lat_yq_old", S_YQ, 32'd9);
      strobe();
      edge_and_settle();
      expect_val("lat_yq_new", S_YQ, 32'd6);
      strobe();

      // All-ones data boundary
      a  = 4'hF;
      oe = 2'd0;
      #1;
      expect_val("ones_y", S_Y, 32'd15);
      strobe();
      edge_and_settle();
      expect_val("ones_yq", S_YQ, 32'd15);
      expect_val("ones_selq", S_SELQ, 32'd0);
      strobe();

`ifdef DATA_SELECTOR_SELCHG_EN
      begin
         logic [1:0] oe_seq [4];
         logic       chg_exp[4];
         oe_seq[0] = 2'd0; oe_seq[1] = 2'd0; oe_seq[2] = 2'd2; oe_seq[3] = 2'd2;
         chg_exp[0] = 1'b0; chg_exp[1] = 1'b0; chg_exp[2] = 1'b1; chg_exp[3] = 1'b0;
         en = 1'b1;
         for (int k = 0; k < 4; k++) begin
            oe = oe_seq[k];
            edge_and_settle();
            expect_val($sformatf("selchg_%0d", k), S_CHG, {31'd0, chg_exp[k]});
            strobe();
         end
         en = 1'b1;
         oe = 2'd1;
         edge_and_settle();
         expect_val("selchg_pulse", S_CHG, 32'd1);
         strobe();
         en = 1'b0;
         oe = 2'd3;
         edge_and_settle();
         expect_val("selchg_en0", S_CHG, 32'd0);
         strobe();
      end
`endif

      #2;
      if (sb_q.size() > 0) begin
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
         n_checks = n_checks + sb_q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
